// File: rtl/shift_sequence_gen.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// repeated N times with an optional idle gap, and pulses done when finished.
module shift_sequence_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid_i,
  output logic                     start_ready_o,
  input  logic [WIDTH-1:0]         pattern_i,
  input  logic [CNT_W-1:0]         repeat_i,
  input  logic                     abort_i,
  output logic                     dout_o,
  output logic                     dout_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(WIDTH)-1:0] bit_idx_o
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = $clog2(GAP + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              done_d;

  logic              dout_q, dout_valid_q, busy_q, done_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              hs_c;

  // Ready is combinational so a request in the done cycle is taken immediately.
  assign start_ready_o = (state_q == S_IDLE) & ~abort_i & ~rst;
  assign hs_c          = start_valid_i & start_ready_o;

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign bit_idx_o    = bit_idx_q;

  // Next-state logic: burst sequencing, shifting and repetition counting.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs_c) begin
          state_d = S_SHIFT;
          shreg_d = pattern_i;
          pat_d   = pattern_i;
          bit_d   = IDX_W'(WIDTH - 1);
          rep_d   = (repeat_i == '0) ? '0 : repeat_i - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          state_d = S_IDLE;
          shreg_d = '0;
          bit_d   = '0;
          rep_d   = '0;
        end else if (bit_q == '0) begin
          if (rep_q != '0) begin
            rep_d   = rep_q - CNT_W'(1);
            shreg_d = pat_q;
            bit_d   = IDX_W'(WIDTH - 1);
            if (GAP > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_W'(GAP - 1);
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            shreg_d = '0;
          end
        end else begin
          shreg_d = shreg_q << 1;
          bit_d   = bit_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (abort_i) begin
          state_d = S_IDLE;
          shreg_d = '0;
          bit_d   = '0;
          rep_d   = '0;
          gap_d   = '0;
        end else if (gap_q == '0) begin
          state_d = S_SHIFT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; outputs reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      pat_q        <= '0;
      bit_q        <= '0;
      rep_q        <= '0;
      gap_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bit_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      pat_q        <= pat_d;
      bit_q        <= bit_d;
      rep_q        <= rep_d;
      gap_q        <= gap_d;
      dout_q       <= (state_d == S_SHIFT) & shreg_d[WIDTH-1];
      dout_valid_q <= (state_d == S_SHIFT);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= done_d;
      bit_idx_q    <= (state_d == S_SHIFT) ? bit_d : '0;
    end
  end

endmodule

// File: tb/tb_shift_sequence_gen.sv
// Bench for shift_sequence_gen: a GAP=1 and a GAP=0 instance, randomized
// requests, and an event scoreboard fed by an arithmetic burst model.
module tb_shift_sequence_gen;

  localparam int W = 4;

  typedef struct {
    int cyc;
    int dut;
    bit is_done;
    int d;
    int idx;
  } ev_t;

  logic       clk, rst;
  logic       sv  [2];
  logic       ab  [2];
  logic [3:0] pat [2];
  logic [3:0] rep [2];
  logic       sr  [2];
  logic       dout[2];
  logic       dv  [2];
  logic       busy[2];
  logic       done[2];
  logic [1:0] idx [2];

  int  cyc;
  int  n_chk, n_fail;
  int  bs [2];
  int  be [2];
  ev_t sbq[$];

  shift_sequence_gen #(.WIDTH(4), .CNT_W(4), .GAP(1)) u_gap1 (
    .clk(clk), .rst(rst), .start_valid_i(sv[0]), .start_ready_o(sr[0]),
    .pattern_i(pat[0]), .repeat_i(rep[0]), .abort_i(ab[0]), .dout_o(dout[0]),
    .dout_valid_o(dv[0]), .busy_o(busy[0]), .done_o(done[0]), .bit_idx_o(idx[0])
  );

  shift_sequence_gen #(.WIDTH(4), .CNT_W(4), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .start_valid_i(sv[1]), .start_ready_o(sr[1]),
    .pattern_i(pat[1]), .repeat_i(rep[1]), .abort_i(ab[1]), .dout_o(dout[1]),
    .dout_valid_o(dv[1]), .busy_o(busy[1]), .done_o(done[1]), .bit_idx_o(idx[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_start_ready"}, int'(sr[d]), 0);
      chk({tag, "_dout"}, int'(dout[d]), 0);
      chk({tag, "_dout_valid"}, int'(dv[d]), 0);
      chk({tag, "_busy"}, int'(busy[d]), 0);
      chk({tag, "_done"}, int'(done[d]), 0);
      chk({tag, "_bit_idx"}, int'(idx[d]), 0);
    end
  endtask

  // Reference: handshake in cycle t gives rep n bursts of W bits separated by G idle cycles.
  task automatic model_accept(input int d, input logic [3:0] p, input logic [3:0] r);
    int n, g;
    ev_t e;
    n = (r == 0) ? 1 : int'(r);
    g = (d == 0) ? 1 : 0;
    for (int rr = 0; rr < n; rr++) begin
      for (int k = W - 1; k >= 0; k--) begin
        e.cyc = cyc + 1 + rr * (W + g) + (W - 1 - k);
        e.dut = d; e.is_done = 1'b0; e.d = int'(p[k]); e.idx = k;
        sbq.push_back(e);
      end
    end
    e.cyc = cyc + 1 + n * W + (n - 1) * g;
    e.dut = d; e.is_done = 1'b1; e.d = 0; e.idx = 0;
    sbq.push_back(e);
    bs[d] = cyc + 1;
    be[d] = cyc + n * W + (n - 1) * g;
  endtask

  task automatic model_cut(input int d, input int last_cyc);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].dut == d && sbq[i].cyc > last_cyc) sbq.delete(i);
    be[d] = last_cyc;
  endtask

  task automatic step(input int d, input bit v, input logic [3:0] p, input logic [3:0] r, input bit a);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin sv[i] = 1'b0; ab[i] = 1'b0; end
    sv[d] = v; ab[d] = a; pat[d] = p; rep[d] = r;
    if (v && !a && cyc > be[d]) model_accept(d, p, r);
    else if (a && cyc >= bs[d] && cyc <= be[d]) model_cut(d, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, pat[0], rep[0], 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    for (int d = 0; d < 2; d++) model_cut(d, -1);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Monitor: per-cycle busy/ready checks and scoreboard pops on any DUT output.
  always @(negedge clk) begin
    int  k, nd;
    bit  act;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        act = (cyc >= bs[d]) && (cyc <= be[d]);
        chk("busy", int'(busy[d]), int'(act));
        chk("start_ready", int'(sr[d]), int'(!act && !ab[d]));
        if (dv[d] || done[d]) begin
          k = -1; nd = 0;
          for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].dut == d) begin
              if (k < 0) k = i;
              nd++;
            end
          end
          chk("event_expected", int'(nd > 0), 1);
          if (k >= 0) begin
            chk("ev_cycle", cyc, sbq[k].cyc);
            chk("ev_done", int'(done[d]), int'(sbq[k].is_done));
            chk("ev_dout", int'(dout[d]), sbq[k].d);
            chk("ev_bit_idx", int'(idx[d]), sbq[k].idx);
            sbq.delete(k);
          end
        end else begin
          chk("idle_dout", int'(dout[d]), 0);
          chk("idle_bit_idx", int'(idx[d]), 0);
        end
      end
    end
  end

  initial begin
    logic [3:0] p, r;
    int d, guard;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; ab[i] = 1'b0; pat[i] = '0; rep[i] = '0;
      bs[i] = 0; be[i] = -1;
    end
    #1;
    chk_zero("reset");
    #22 rst = 1'b0;

    // Single burst and multi-repeat with gaps
    step(0, 1'b1, 4'b1100, 4'd1, 1'b0); idle(6);
    step(0, 1'b1, 4'b1011, 4'd3, 1'b0); idle(16);

    // Back-to-back repetitions and repeat=0
    step(1, 1'b1, 4'b0110, 4'd2, 1'b0); idle(10);
    step(1, 1'b1, 4'b0110, 4'd0, 1'b0); idle(6);

    // Valid held high with changing pattern: only done-cycle handshakes taken
    for (int i = 0; i < 25; i++) begin
      p = 4'($urandom); r = 4'($urandom_range(1, 3));
      step(0, 1'b1, p, r, 1'b0);
    end
    idle(16);

    // Abort mid-burst, then abort together with a request in IDLE
    p = 4'($urandom);
    step(0, 1'b1, p, 4'd2, 1'b0);
    step(0, 1'b0, p, 4'd2, 1'b0);
    step(0, 1'b0, p, 4'd2, 1'b1);
    idle(3);
    step(0, 1'b1, 4'b1111, 4'd1, 1'b1);
    idle(6);

    // Abort on the last bit suppresses done
    step(1, 1'b1, 4'b1001, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 1'b0, 4'b1001, 4'd1, 1'b0);
    step(1, 1'b0, 4'b1001, 4'd1, 1'b1);
    idle(4);

    // Asynchronous reset mid-shift, then a clean burst
    step(0, 1'b1, 4'b1010, 4'd3, 1'b0);
    idle(2);
    async_reset();
    step(0, 1'b1, 4'b0101, 4'd1, 1'b0); idle(6);

    // Maximum repeat count
    step(1, 1'b1, 4'b1101, 4'd15, 1'b0); idle(62);
    step(0, 1'b1, 4'b0011, 4'd15, 1'b0); idle(76);

    // Randomized traffic on both instances
    for (int i = 0; i < 150; i++) begin
      d = int'($urandom_range(0, 1));
      p = 4'($urandom);
      r = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      step(d, ($urandom_range(0, 3) != 0), p, r, ($urandom_range(0, 11) == 0));
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      idle(1);
      guard++;
    end
    idle(2);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequence_gen.md
Name: shift_sequence_gen

Overview:
Serial pattern transmitter, the generator side of the team's serial sequence detectors.
- Accepts a WIDTH-bit pattern and a repeat count over a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, with an optional idle gap between repetitions.
- Drives detector benches and on-chip serial links. Pulses done when the burst completes.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
CNT_W, 4, width of repeat-count input
GAP, 1, idle cycles inserted between repetitions (0 = back-to-back)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start_valid  input  1  request to transmit pattern/repeat
start_ready  output  1  high only in IDLE and abort low; handshake = start_valid & start_ready at posedge
pattern  input  WIDTH  pattern, sampled at handshake
repeat  input  CNT_W  number of transmissions, sampled at handshake; 0 treated as 1
abort  input  1  synchronous cancel of an active burst
dout  output  1  serial data, MSB-first
dout_valid  output  1  high while dout carries a pattern bit
busy  output  1  high from cycle after handshake until return to IDLE
done  output  1  one-cycle pulse after final bit of final repetition
bit_idx  output  clog2(WIDTH)  index of bit currently on dout (WIDTH-1 down to 0), 0 when idle

Behaviour:
- Decided interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values while rst is high and after it deasserts:
  - dout, dout_valid, busy, done, bit_idx = 0; start_ready = 0.
  - FSM in IDLE; shift register and repeat counter cleared.
- Reset asserted mid-burst clears all state immediately. No done pulse. IDLE after release.
- All outputs except start_ready are registered. start_ready = (state==IDLE) & !abort.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE -> SHIFT on handshake.
    - Load shift reg = pattern, bit counter = WIDTH-1, rep counter = max(repeat,1)-1.
  - SHIFT: dout = shreg[WIDTH-1], dout_valid = 1, busy = 1. Shift left each cycle; bit counter decrements.
  - After the bit with bit_idx = 0:
    - If rep counter > 0 and GAP > 0: -> GAP. Reload shift reg from latched pattern; rep counter decrements.
    - If rep counter > 0 and GAP == 0: stay in SHIFT. Next cycle carries pattern MSB, no bubble.
    - If rep counter == 0: -> IDLE. done = 1 for exactly one cycle (first IDLE cycle); start_ready = 1 in that same cycle.
  - GAP: dout = 0, dout_valid = 0, busy = 1 for exactly GAP cycles, then -> SHIFT.
- Latency: first bit appears on dout the cycle after the handshake edge.
- Burst length: repeat*WIDTH + (repeat-1)*GAP cycles, then done.
- New handshake is accepted in the done cycle. The next burst starts the following cycle, back-to-back with no extra idle.
- pattern/repeat changes while busy are ignored; the latched copy is used.
- abort in SHIFT or GAP:
  - Next cycle: IDLE, dout_valid = 0, dout = 0, busy = 0, no done.
  - Abort in IDLE is ignored.
  - Abort coincident with start_valid in IDLE: request not accepted (start_ready low).
- Abort on the cycle of the last bit: abort wins, no done pulse.
- Counter widths must not wrap for repeat = 2^CNT_W-1.

Test Plan:
1. WIDTH=4, GAP=1, pattern 4'b1100, repeat=1, handshake at cycle 0 -> dout 1,1,0,0 with dout_valid=1 in cycles 1-4; bit_idx 3,2,1,0; done=1 in cycle 5 only; busy cycles 1-4.
2. pattern 4'b1011, repeat=3, GAP=1 -> bits 1011 _ 1011 _ 1011; dout_valid low in cycles 5 and 10; done in cycle 15.
3. GAP=0 build, pattern 4'b0110, repeat=2 -> 8 contiguous valid bits 01100110 in cycles 1-8; done in cycle 9; repeat=0 gives same as repeat=1.
4. start_valid held high through burst with pattern changing -> only the done-cycle handshake accepted; second burst starts the cycle after done with the then-current pattern.
5. abort in cycle 2 of a repeat=2 burst -> cycle 3: dout_valid=0, busy=0, start_ready=1; done never pulses. Abort + start_valid together in IDLE -> no burst.
6. rst pulsed asynchronously (between edges) mid-SHIFT -> outputs 0 immediately; after release start_ready=1 and a new burst runs cleanly.
